// File: rtl/data_bus_controller_if.sv
// Purpose : CPU data-memory port plus transmit-byte stream between core, controller and serializer.
// Latency : load data combinational from address; stores and tx pops take effect on the clock edge.
// Backpressure: tx stream is valid/ready; the memory port never stalls.
// Ports   : memory_write_en/memory_address/memory_write_value from core, memory_read_value back;
//           tx_data/tx_valid towards serializer, tx_ready back.
interface data_bus_controller_if;
  logic        memory_write_en;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic [31:0] memory_read_value;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // Core plus serializer side.
  modport master (
    output memory_write_en, memory_address, memory_write_value, tx_ready,
    input  memory_read_value, tx_data, tx_valid
  );

  // Controller side.
  modport slave (
    input  memory_write_en, memory_address, memory_write_value, tx_ready,
    output memory_read_value, tx_data, tx_valid
  );
endinterface

// File: rtl/data_bus_controller.sv
// Purpose : decodes core loads/stores into data RAM, MMIO registers (GPIO, timer, status) and a tx byte FIFO.
// Latency : loads combinational (same cycle); stores visible next cycle; pushed byte on tx_data next cycle.
// Backpressure: tx FIFO drains on tx_valid && tx_ready; a push into a full FIFO without a pop is dropped and flags overflow.
// Ports   : clock, reset (sync, active high), bus (slave modport of data_bus_controller_if),
//           gpio_out (GPIO register), timer_irq (sticky timer match).
module data_bus_controller #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  data_bus_controller_if.slave  bus,
  output logic [31:0]           gpio_out,
  output logic                  timer_irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS * 4);

  localparam logic [5:0] REG_GPIO   = 6'd0;
  localparam logic [5:0] REG_COUNT  = 6'd1;
  localparam logic [5:0] REG_CMP    = 6'd2;
  localparam logic [5:0] REG_STATUS = 6'd3;
  localparam logic [5:0] REG_TX     = 6'd4;

  logic [31:0] ram [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [31:0] timer_count;
  logic [31:0] timer_cmp;
  logic        match;
  logic        overflow;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   fifo_cnt;

  // Byte offset bits are don't-care for every region.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.memory_address[1:0];

  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [5:0]    reg_sel;

  assign ram_hit  = bus.memory_address < RAM_LIMIT;
  assign mmio_hit = bus.memory_address[31:8] == MMIO_BASE[31:8];
  assign ram_idx  = bus.memory_address[AW+1:2];
  assign reg_sel  = bus.memory_address[7:2];

  logic ram_we, wr_gpio, wr_count, wr_cmp, wr_status, push_req;
  assign ram_we    = bus.memory_write_en && ram_hit && !reset;
  assign wr_gpio   = bus.memory_write_en && mmio_hit && (reg_sel == REG_GPIO);
  assign wr_count  = bus.memory_write_en && mmio_hit && (reg_sel == REG_COUNT);
  assign wr_cmp    = bus.memory_write_en && mmio_hit && (reg_sel == REG_CMP);
  assign wr_status = bus.memory_write_en && mmio_hit && (reg_sel == REG_STATUS);
  assign push_req  = bus.memory_write_en && mmio_hit && (reg_sel == REG_TX);

  logic fifo_full, fifo_empty, pop, push_ok;
  assign fifo_full  = fifo_cnt == (PW+1)'(FIFO_DEPTH);
  assign fifo_empty = fifo_cnt == '0;
  assign pop        = !fifo_empty && bus.tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
  assign timer_irq    = match;

  always_comb begin
    bus.memory_read_value = 32'h0;
    if (ram_hit) begin
      bus.memory_read_value = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_GPIO:   bus.memory_read_value = gpio_out;
        REG_COUNT:  bus.memory_read_value = timer_count;
        REG_CMP:    bus.memory_read_value = timer_cmp;
        REG_STATUS: bus.memory_read_value = {28'h0, overflow, fifo_empty, fifo_full, match};
        default:    bus.memory_read_value = 32'h0;
      endcase
    end
  end

  // Storage arrays carry no reset; reads of the FIFO are masked by tx_valid.
  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_idx] <= bus.memory_write_value;
    if (push_ok && !reset) fifo_mem[wr_ptr] <= bus.memory_write_value[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gpio_out    <= 32'h0;
      timer_count <= 32'h0;
      timer_cmp   <= 32'hFFFF_FFFF;
      match       <= 1'b0;
      overflow    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
    end else begin
      if (wr_gpio) gpio_out <= bus.memory_write_value;
      if (wr_cmp)  timer_cmp <= bus.memory_write_value;
      timer_count <= wr_count ? bus.memory_write_value : timer_count + 32'd1;

      // Set beats a coincident write-one-to-clear.
      if (timer_count == timer_cmp)                 match <= 1'b1;
      else if (wr_status && bus.memory_write_value[0]) match <= 1'b0;

      if (push_req && !push_ok)                     overflow <= 1'b1;
      else if (wr_status && bus.memory_write_value[3]) overflow <= 1'b0;

      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push_ok && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push_ok) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

endmodule
